// File: rtl/gavgpool_arb.sv
// Round-robin arbiter sharing one gavgpool between NUM_CH streams, tagging each average with its channel.
// Define GAVGPOOL_ARB_B2B_EN to chain grants back-to-back without the one-cycle arbitration bubble.
module gavgpool_arb #(
    parameter int DATA_WIDTH = 12,
    parameter int POOL_SIZE  = 250,
    parameter int NUM_CH     = 4,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_valid_in,
    output logic [NUM_CH-1:0]              ch_ready_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data_in,
    input  logic                           pool_ready_in,
    output logic                           pool_valid_in,
    output logic [DATA_WIDTH-1:0]          pool_data_in,
    output logic                           pool_ready_out,
    input  logic                           pool_valid_out,
    input  logic [DATA_WIDTH-1:0]          pool_data_out,
    input  logic                           res_ready_out,
    output logic                           res_valid_out,
    output logic [DATA_WIDTH-1:0]          res_data_out,
    output logic [$clog2(NUM_CH)-1:0]      res_ch_out
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam int AW    = $clog2(TAG_DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   last_ch;
    logic [CNT_W-1:0]  beat_cnt;

    logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;

    logic              hs;
    logic              last_beat;
    logic              push;
    logic              pop;
    logic [CH_W-1:0]   idle_pick;

    // Lowest offset after 'last' wins: scan from the far end so nearer hits overwrite.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   last);
        logic [CH_W-1:0] pick;
        int              idx;
        pick = last;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_CH;
            if (req[idx]) pick = CH_W'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        ch_ready_in   = '0;
        pool_valid_in = 1'b0;
        pool_data_in  = '0;
        if (state == STREAM) begin
            pool_valid_in      = ch_valid_in[grant];
            pool_data_in       = ch_data_in[grant*DATA_WIDTH +: DATA_WIDTH];
            ch_ready_in[grant] = pool_ready_in;
        end
    end

    assign hs         = pool_valid_in & pool_ready_in;
    assign last_beat  = hs && (beat_cnt == CNT_W'(POOL_SIZE - 1));
    assign push       = last_beat;
    assign pop        = res_valid_out & res_ready_out;
    assign idle_pick  = rr_pick(ch_valid_in, last_ch);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Results are only presented once a tag exists, which also keeps them quiet through reset.
    assign res_valid_out  = pool_valid_out & ~fifo_empty;
    assign res_data_out   = pool_data_out;
    assign res_ch_out     = fifo_empty ? '0 : tag_mem[rd_ptr[AW-1:0]];
    assign pool_ready_out = res_ready_out;

`ifdef GAVGPOOL_ARB_B2B_EN
    logic            b2b_room;
    logic [CH_W-1:0] b2b_pick;
    assign b2b_room = (int'(wr_ptr - rd_ptr) + 1 - int'(pop)) < TAG_DEPTH;
    assign b2b_pick = rr_pick(ch_valid_in, grant);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            last_ch  <= CH_W'(NUM_CH - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|ch_valid_in && !fifo_full) begin
                        grant    <= idle_pick;
                        beat_cnt <= '0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (last_beat) begin
                        last_ch  <= grant;
                        beat_cnt <= '0;
`ifdef GAVGPOOL_ARB_B2B_EN
                        if (|ch_valid_in && b2b_room) grant <= b2b_pick;
                        else                          state <= IDLE;
`else
                        state    <= IDLE;
`endif
                    end else if (hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: tag storage has no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr[AW-1:0]] <= grant;
    end

`ifndef SYNTHESIS
    no_result_without_tag: assert property (@(posedge clk) disable iff (!rst)
        !(pool_valid_out && fifo_empty));
`endif

endmodule

// File: tb/tb_gavgpool_arb.sv
// Directed bench for gavgpool_arb with POOL_SIZE=4; the bench itself plays the shared gavgpool.
module tb_gavgpool_arb;

    localparam int DW = 12;
    localparam int PS = 4;
    localparam int NC = 4;
    localparam int TD = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NC-1:0]   ch_valid;
    logic [NC-1:0]   ch_ready;
    logic [NC*DW-1:0] ch_data;
    logic            pool_ready;
    logic            pool_valid_in;
    logic [DW-1:0]   pool_data_in;
    logic            pool_ready_out;
    logic            pool_valid_out;
    logic [DW-1:0]   pool_data_out;
    logic            res_ready;
    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic [1:0]      res_ch;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gavgpool_arb #(.DATA_WIDTH(DW), .POOL_SIZE(PS), .NUM_CH(NC), .TAG_DEPTH(TD)) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_valid_in    (ch_valid),
        .ch_ready_in    (ch_ready),
        .ch_data_in     (ch_data),
        .pool_ready_in  (pool_ready),
        .pool_valid_in  (pool_valid_in),
        .pool_data_in   (pool_data_in),
        .pool_ready_out (pool_ready_out),
        .pool_valid_out (pool_valid_out),
        .pool_data_out  (pool_data_out),
        .res_ready_out  (res_ready),
        .res_valid_out  (res_valid),
        .res_data_out   (res_data),
        .res_ch_out     (res_ch)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int c, input int v);
        ch_data[c*DW +: DW] = DW'(v);
    endtask

    task automatic do_reset;
        rst            = 1'b0;
        ch_valid       = '0;
        ch_data        = '0;
        pool_ready     = 1'b1;
        pool_valid_out = 1'b0;
        pool_data_out  = '0;
        res_ready      = 1'b1;
        tick;
        tick;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, with requests and a stray pool result present
        ch_valid       = '1;
        ch_data        = '0;
        pool_ready     = 1'b1;
        pool_valid_out = 1'b1;
        pool_data_out  = DW'(55);
        res_ready      = 1'b1;
        #2;
        check("rst_ch_ready",   32'(ch_ready),      32'(0));
        check("rst_pool_valid", 32'(pool_valid_in), 32'(0));
        check("rst_res_valid",  32'(res_valid),     32'(0));
        check("rst_res_ch",     32'(res_ch),        32'(0));
        do_reset;

`ifndef GAVGPOOL_ARB_B2B_EN
        // T1: ch0 alone, 4,8,12,16 -> average 10 tagged 0
        ch_valid = 4'b0001;
        set_data(0, 4);
        #1;
        check("t1_bubble_ready", 32'(ch_ready),      32'(0));
        check("t1_bubble_valid", 32'(pool_valid_in), 32'(0));
        for (int k = 0; k < 4; k++) begin
            tick;
            set_data(0, 4 * (k + 1));
            #1;
            check("t1_ready", 32'(ch_ready),      32'(4'b0001));
            check("t1_valid", 32'(pool_valid_in), 32'(1));
            check("t1_data",  32'(pool_data_in),  32'(4 * (k + 1)));
        end
        tick;
        ch_valid       = '0;
        pool_valid_out = 1'b1;
        pool_data_out  = DW'(10);
        #1;
        check("t1_post_ready",  32'(ch_ready),       32'(0));
        check("t1_post_valid",  32'(pool_valid_in),  32'(0));
        check("t1_res_valid",   32'(res_valid),      32'(1));
        check("t1_res_data",    32'(res_data),       32'(10));
        check("t1_res_ch",      32'(res_ch),         32'(0));
        check("t1_pool_ready",  32'(pool_ready_out), 32'(1));
        tick;
        pool_valid_out = 1'b0;
        #1;
        check("t1_res_gone",    32'(res_valid),      32'(0));
        check("t1_no_regrant",  32'(ch_ready),       32'(0));

        // T2: all channels, ch c sends c*10; grants 0,1,2,3 repeating with a bubble
        do_reset;
        ch_valid = '1;
        for (int c = 0; c < NC; c++) set_data(c, c * 10);
        for (int p = 0; p < 8; p++) begin
            if (p > 0) begin
                tick;
                pool_valid_out = 1'b1;
                pool_data_out  = DW'(((p - 1) % 4) * 10);
            end
            #1;
            check("t2_bubble_ready", 32'(ch_ready),      32'(0));
            check("t2_bubble_valid", 32'(pool_valid_in), 32'(0));
            if (p > 0) begin
                check("t2_res_valid", 32'(res_valid), 32'(1));
                check("t2_res_ch",    32'(res_ch),    32'((p - 1) % 4));
                check("t2_res_data",  32'(res_data),  32'(((p - 1) % 4) * 10));
            end
            for (int k = 0; k < 4; k++) begin
                tick;
                pool_valid_out = 1'b0;
                #1;
                check("t2_ready", 32'(ch_ready),     32'(1 << (p % 4)));
                check("t2_data",  32'(pool_data_in), 32'((p % 4) * 10));
            end
        end
        tick;
        ch_valid       = '0;
        pool_valid_out = 1'b1;
        pool_data_out  = DW'(30);
        #1;
        check("t2_last_res_ch",   32'(res_ch),   32'(3));
        check("t2_last_res_data", 32'(res_data), 32'(30));
        tick;
        pool_valid_out = 1'b0;

        // T3: ch2 stalls mid-pool while ch1 requests; no re-grant
        do_reset;
        ch_valid = 4'b0100;
        set_data(2, 1);
        set_data(1, 99);
        #1;
        check("t3_bubble_valid", 32'(pool_valid_in), 32'(0));
        tick;
        #1;
        check("t3_b1_ready", 32'(ch_ready),     32'(4'b0100));
        check("t3_b1_data",  32'(pool_data_in), 32'(1));
        tick;
        set_data(2, 2);
        #1;
        check("t3_b2_data",  32'(pool_data_in), 32'(2));
        for (int i = 0; i < 5; i++) begin
            tick;
            ch_valid = 4'b0010;
            #1;
            check("t3_stall_ready", 32'(ch_ready),      32'(4'b0100));
            check("t3_stall_valid", 32'(pool_valid_in), 32'(0));
        end
        tick;
        ch_valid = 4'b0110;
        set_data(2, 3);
        #1;
        check("t3_b3_valid", 32'(pool_valid_in), 32'(1));
        check("t3_b3_data",  32'(pool_data_in),  32'(3));
        check("t3_b3_ready", 32'(ch_ready),      32'(4'b0100));
        tick;
        set_data(2, 4);
        #1;
        check("t3_b4_data",  32'(pool_data_in),  32'(4));
        tick;
        pool_valid_out = 1'b1;
        pool_data_out  = DW'(2);
        #1;
        check("t3_bubble2_ready", 32'(ch_ready),      32'(0));
        check("t3_bubble2_valid", 32'(pool_valid_in), 32'(0));
        check("t3_res_ch",        32'(res_ch),        32'(2));
        check("t3_res_data",      32'(res_data),      32'(2));
        tick;
        pool_valid_out = 1'b0;
        #1;
        check("t3_next_ready", 32'(ch_ready),     32'(4'b0010));
        check("t3_next_data",  32'(pool_data_in), 32'(99));

        // T4: results back-pressured; tag FIFO fills after 4 pools, then drains in order
        do_reset;
        ch_valid  = '1;
        res_ready = 1'b0;
        for (int c = 0; c < NC; c++) set_data(c, c * 10);
        for (int p = 0; p < 4; p++) begin
            if (p > 0) tick;
            #1;
            check("t4_bubble_ready", 32'(ch_ready), 32'(0));
            for (int k = 0; k < 4; k++) begin
                tick;
                #1;
                check("t4_ready", 32'(ch_ready), 32'(1 << p));
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            #1;
            check("t4_full_ready", 32'(ch_ready),      32'(0));
            check("t4_full_valid", 32'(pool_valid_in), 32'(0));
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            pool_valid_out = 1'b1;
            pool_data_out  = DW'(i * 10);
            res_ready      = 1'b1;
            #1;
            check("t4_drain_valid", 32'(res_valid), 32'(1));
            check("t4_drain_ch",    32'(res_ch),    32'(i));
            check("t4_drain_data",  32'(res_data),  32'(i * 10));
            check("t4_resume_ready", 32'(ch_ready), (i >= 2) ? 32'(4'b0001) : 32'(0));
        end
        tick;
        pool_valid_out = 1'b0;
        ch_valid       = '0;

        // T5: reset on beat 2 of a ch1 pool discards it; ch0 wins afterwards
        do_reset;
        ch_valid = 4'b0010;
        set_data(1, 50);
        #1;
        tick;
        #1;
        check("t5_b1_ready", 32'(ch_ready),     32'(4'b0010));
        check("t5_b1_data",  32'(pool_data_in), 32'(50));
        tick;
        set_data(1, 60);
        #1;
        check("t5_b2_data",  32'(pool_data_in), 32'(60));
        rst            = 1'b0;
        pool_valid_out = 1'b1;
        #1;
        check("t5_rst_ready",     32'(ch_ready),      32'(0));
        check("t5_rst_valid",     32'(pool_valid_in), 32'(0));
        check("t5_rst_res_valid", 32'(res_valid),     32'(0));
        check("t5_rst_res_ch",    32'(res_ch),        32'(0));
        pool_valid_out = 1'b0;
        tick;
        rst      = 1'b1;
        ch_valid = 4'b0011;
        set_data(0, 1);
        #1;
        check("t5_bubble_valid", 32'(pool_valid_in), 32'(0));
        for (int k = 0; k < 4; k++) begin
            tick;
            set_data(0, k + 1);
            #1;
            check("t5_ready", 32'(ch_ready),     32'(4'b0001));
            check("t5_data",  32'(pool_data_in), 32'(k + 1));
        end
        tick;
        ch_valid       = '0;
        pool_valid_out = 1'b1;
        pool_data_out  = DW'(2);
        #1;
        check("t5_post_ready", 32'(ch_ready),  32'(0));
        check("t5_res_valid",  32'(res_valid), 32'(1));
        check("t5_res_ch",     32'(res_ch),    32'(0));
        tick;
        pool_valid_out = 1'b0;
        #1;
        check("t5_res_gone",   32'(res_valid), 32'(0));
`else
        // B2B: ch0 and ch1 continuous; pools chain with no idle cycle
        ch_valid = 4'b0011;
        set_data(0, 5);
        set_data(1, 7);
        #1;
        check("b2b_first_bubble", 32'(pool_valid_in), 32'(0));
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                tick;
                pool_valid_out = (k == 0) && (p > 0);
                pool_data_out  = DW'(((p - 1) % 2 == 0) ? 5 : 7);
                #1;
                check("b2b_valid", 32'(pool_valid_in), 32'(1));
                check("b2b_ready", 32'(ch_ready),      32'(1 << (p % 2)));
                check("b2b_data",  32'(pool_data_in),  32'((p % 2 == 0) ? 5 : 7));
                if (k == 0 && p > 0) check("b2b_res_ch", 32'(res_ch), 32'((p - 1) % 2));
            end
        end
        tick;
        ch_valid       = '0;
        pool_valid_out = 1'b1;
        pool_data_out  = DW'(7);
        #1;
        check("b2b_last_res_ch", 32'(res_ch), 32'(1));
        tick;
        pool_valid_out = 1'b0;
`endif

        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
